// File: rtl/pipeline_pkg.sv
// Shared fetch-stage definitions: data width, reset/bubble constants and the
// IF/ID pipeline payload.
package pipeline_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT  = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP_INSTR_DEFAULT = 32'h0000_0013; // addi x0,x0,0

  // Contents of the IF/ID pipeline register.
  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic            valid;
  } if_id_t;

  // Payload used whenever Decode must see a bubble instead of a real fetch.
  function automatic if_id_t make_bubble(input logic [XLEN-1:0] nop);
    if_id_t b;
    b.instr    = nop;
    b.pc       = '0;
    b.pc_plus4 = '0;
    b.valid    = 1'b0;
    return b;
  endfunction

  // Word-align a redirect target by clearing the two low bits.
  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register. Per edge: reset > flush > stall > load.
// Reset and flush both load the bubble payload.
module if_id_reg
  import pipeline_pkg::*;
#(
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   stall,
  input  logic   flush,
  input  if_id_t d,
  output if_id_t q
);

  if_id_t r_q;

  // IF/ID register: bubble on reset or flush, hold on stall, otherwise capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_q <= make_bubble(NOP_INSTR);
    end else if (flush) begin
      r_q <= make_bubble(NOP_INSTR);
    end else if (!stall) begin
      r_q <= d;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, next-PC selection, IF/ID register,
// sticky misaligned-redirect flag and count of instructions delivered to Decode.
module fetch_unit
  import pipeline_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_f,
  input  logic        stall_d,
  input  logic        flush_d,
  input  logic        pc_src_e,
  input  logic [31:0] pc_target_e,
  input  logic [31:0] imem_rd,
  output logic [31:0] pc_f,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic [31:0] pc_plus4_d,
  output logic        valid_d,
  output logic        misalign_err,
  output logic [31:0] fetch_count
);

  logic [31:0] r_pc;
  logic        r_misalign_err;
  logic [31:0] r_fetch_count;

  logic [31:0] w_pc_plus4;
  logic [31:0] w_pc_next;
  logic        w_pc_en;
  logic        w_flush;
  logic        w_load;
  if_id_t      w_if_d;
  if_id_t      w_if_q;

  // Sequential fetch wraps naturally through 32-bit modulo addition.
  assign w_pc_plus4 = r_pc + 32'd4;
  assign w_pc_next  = pc_src_e ? align_word(pc_target_e) : w_pc_plus4;

  // A redirect must never be lost, so it overrides a fetch stall.
  assign w_pc_en = !stall_f || pc_src_e;

  // A taken branch squashes the wrong-path instruction currently in fetch.
  assign w_flush = flush_d || pc_src_e;

  // A real instruction enters Decode only when neither squashed nor stalled.
  assign w_load = !w_flush && !stall_d;

  assign w_if_d.instr    = imem_rd;
  assign w_if_d.pc       = r_pc;
  assign w_if_d.pc_plus4 = w_pc_plus4;
  assign w_if_d.valid    = 1'b1;

  // PC register: reset vector, else advance or redirect unless stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc <= RESET_PC;
    end else if (w_pc_en) begin
      r_pc <= w_pc_next;
    end
  end

  // Sticky flag for any redirect whose target is not word aligned.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_misalign_err <= 1'b0;
    end else if (pc_src_e && (pc_target_e[1:0] != 2'b00)) begin
      r_misalign_err <= 1'b1;
    end
  end

  // Count instructions actually accepted into Decode; bubbles and holds excluded.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_count <= '0;
    end else if (w_load) begin
      r_fetch_count <= r_fetch_count + 32'd1;
    end
  end

  if_id_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id (
    .clk   (clk),
    .reset (reset),
    .stall (stall_d),
    .flush (w_flush),
    .d     (w_if_d),
    .q     (w_if_q)
  );

  assign pc_f         = r_pc;
  assign instr_d      = w_if_q.instr;
  assign pc_d         = w_if_q.pc;
  assign pc_plus4_d   = w_if_q.pc_plus4;
  assign valid_d      = w_if_q.valid;
  assign misalign_err = r_misalign_err;
  assign fetch_count  = r_fetch_count;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: stimulus drives inputs on the falling edge
// and queues the state the fetch stage should show after the next rising edge;
// a monitor pops and compares just after every rising edge.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk;
  logic        reset;
  logic        stall_f;
  logic        stall_d;
  logic        flush_d;
  logic        pc_src_e;
  logic [31:0] pc_target_e;
  logic [31:0] imem_rd;
  logic [31:0] pc_f;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic [31:0] pc_plus4_d;
  logic        valid_d;
  logic        misalign_err;
  logic [31:0] fetch_count;

  fetch_unit #(
    .RESET_PC  (RST_PC),
    .NOP_INSTR (NOP)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .stall_f      (stall_f),
    .stall_d      (stall_d),
    .flush_d      (flush_d),
    .pc_src_e     (pc_src_e),
    .pc_target_e  (pc_target_e),
    .imem_rd      (imem_rd),
    .pc_f         (pc_f),
    .instr_d      (instr_d),
    .pc_d         (pc_d),
    .pc_plus4_d   (pc_plus4_d),
    .valid_d      (valid_d),
    .misalign_err (misalign_err),
    .fetch_count  (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory contents: a fixed scramble of the address so that
  // every word fetched is distinguishable.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A3C_9617;
  endfunction

  assign imem_rd = mem_word(pc_f);

  typedef struct packed {
    logic [31:0] pc_f;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        valid;
    logic        err;
    logic [31:0] cnt;
  } exp_t;

  exp_t exp_q[$];

  int checks   = 0;
  int failures = 0;

  // Architectural model of the fetch stage.
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_pcd;
  logic [31:0] m_pc4;
  logic        m_valid;
  logic        m_err;
  logic [31:0] m_cnt;

  function automatic void model_bubble();
    m_instr = NOP;
    m_pcd   = 32'd0;
    m_pc4   = 32'd0;
    m_valid = 1'b0;
  endfunction

  // Apply one cycle of inputs and queue the expected post-edge state.
  task automatic step(input logic rst, input logic sf, input logic sd,
                      input logic fl, input logic src, input logic [31:0] tgt);
    logic [31:0] old_pc;
    exp_t e;
    @(negedge clk);
    reset       = rst;
    stall_f     = sf;
    stall_d     = sd;
    flush_d     = fl;
    pc_src_e    = src;
    pc_target_e = tgt;
    old_pc = m_pc;
    if (rst) begin
      m_pc  = RST_PC;
      model_bubble();
      m_err = 1'b0;
      m_cnt = 32'd0;
    end else begin
      // Next fetch address: redirect to the word containing the target,
      // otherwise the following word unless fetch is held.
      if (src)      m_pc = tgt & 32'hFFFF_FFFC;
      else if (!sf) m_pc = old_pc + 32'd4;
      // Decode side: squash on flush or taken branch, hold on stall,
      // otherwise receive the word at the old fetch address.
      if (fl || src) begin
        model_bubble();
      end else if (!sd) begin
        m_instr = mem_word(old_pc);
        m_pcd   = old_pc;
        m_pc4   = old_pc + 32'd4;
        m_valid = 1'b1;
        m_cnt   = m_cnt + 32'd1;
      end
      if (src && (tgt[1:0] != 2'b00)) m_err = 1'b1;
    end
    e.pc_f  = m_pc;
    e.instr = m_instr;
    e.pc    = m_pcd;
    e.pc4   = m_pc4;
    e.valid = m_valid;
    e.err   = m_err;
    e.cnt   = m_cnt;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", nm, $time, act, exp);
    end
  endtask

  // Monitor: compare the registered outputs shortly after each rising edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("pc_f",         pc_f,                 e.pc_f);
      chk("instr_d",      instr_d,              e.instr);
      chk("pc_d",         pc_d,                 e.pc);
      chk("pc_plus4_d",   pc_plus4_d,           e.pc4);
      chk("valid_d",      {31'd0, valid_d},     {31'd0, e.valid});
      chk("misalign_err", {31'd0, misalign_err}, {31'd0, e.err});
      chk("fetch_count",  fetch_count,          e.cnt);
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        r_rst, r_sf, r_sd, r_fl, r_src;
    logic [31:0] r_tgt;
    reset = 1'b1; stall_f = 1'b0; stall_d = 1'b0; flush_d = 1'b0;
    pc_src_e = 1'b0; pc_target_e = 32'd0;
    m_pc = RST_PC; model_bubble(); m_err = 1'b0; m_cnt = 32'd0;

    // Reset, then free running fetch.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    idle(2);
    // Full stall at pc_f=0x8 for two cycles, then resume.
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
    idle(3);
    // Redirect while fetch is stalled.
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0100);
    idle(3);
    // Misaligned redirect target; flag must stay set.
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0102);
    idle(3);
    // Flush together with decode stall.
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
    idle(2);
    // PC wrap at the top of the address space.
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    idle(3);
    // Reset landing in the middle of a stall and redirect.
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0042);
    idle(3);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      r_rst = ($urandom_range(63) == 0);
      r_sf  = ($urandom_range(3) == 0);
      r_sd  = ($urandom_range(3) == 0);
      r_fl  = ($urandom_range(7) == 0);
      r_src = ($urandom_range(7) == 0);
      r_tgt = $urandom;
      if ($urandom_range(3) != 0) r_tgt[1:0] = 2'b00;
      step(r_rst, r_sf, r_sd, r_fl, r_src, r_tgt);
    end

    idle(2);
    @(negedge clk);
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC value loaded by reset.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0013: bubble instruction (addi x0,x0,0).
REQ-003 clk  input  1  rising-edge clock, single clock domain.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 stall_f  input  1  hold PC (hazard unit).
REQ-006 stall_d  input  1  hold IF/ID register (hazard unit).
REQ-007 flush_d  input  1  replace IF/ID contents with bubble.
REQ-008 pc_src_e  input  1  taken branch/jump resolved in Execute.
REQ-009 pc_target_e  input  32  branch/jump target from Execute adder.
REQ-010 imem_rd  input  32  instruction memory read data, combinational on pc_f.
REQ-011 pc_f  output  32  current fetch PC, drives instruction memory address.
REQ-012 instr_d  output  32  registered instruction to Decode.
REQ-013 pc_d  output  32  registered PC of instr_d.
REQ-014 pc_plus4_d  output  32  registered pc_d+4.
REQ-015 valid_d  output  1  instr_d is a real fetched instruction, not a bubble.
REQ-016 misalign_err  output  1  sticky flag: a redirect target had bits [1:0] != 0.
REQ-017 fetch_count  output  32  count of instructions accepted into Decode.

Function
REQ-018 Next PC: pc_src_e ? {pc_target_e[31:2],2'b00} : pc_f+4, 32-bit modulo add, wraps 32'hFFFF_FFFC -> 32'h0000_0000.
REQ-019 pc_f updates on each rising edge when stall_f=0 or pc_src_e=1; otherwise holds.
REQ-020 pc_src_e=1 takes priority over stall_f=1: redirect is never lost.
REQ-021 IF/ID priority per edge: reset > (flush_d or pc_src_e) > stall_d > load.
REQ-022 Bubble load: instr_d=NOP_INSTR, pc_d=0, pc_plus4_d=0, valid_d=0.
REQ-023 Normal load: instr_d=imem_rd, pc_d=pc_f, pc_plus4_d=pc_f+4, valid_d=1.
REQ-024 stall_d=1 with no flush: all IF/ID outputs hold, including valid_d.
REQ-025 Redirect latency: target appears on pc_f one edge after pc_src_e sampled; target instruction reaches instr_d on the following edge; exactly one bubble is inserted.
REQ-026 misalign_err sets on any edge with pc_src_e=1 and pc_target_e[1:0]!=0, and holds until reset.
REQ-027 fetch_count increments by 1 on each normal load (REQ-023), wraps at 2^32-1 -> 0, and never counts bubbles or stalled cycles.
REQ-028 All outputs are registered except pc_f's combinational fanout to memory; no combinational path from inputs to instr_d, pc_d or valid_d.

Reset
REQ-029 On reset=1 at a clock edge: pc_f=RESET_PC, IF/ID holds the bubble (REQ-022), misalign_err=0, fetch_count=0.
REQ-030 Reset overrides every other input on the same edge, including pc_src_e, stall_f and flush_d.
REQ-031 Reset asserted mid-stall or mid-redirect discards the pending state; the first normal load after deassertion captures the instruction at RESET_PC.

Structure
REQ-032 Package pipeline_pkg holds XLEN=32, RESET_PC default, NOP_INSTR, and a struct type if_id_t {instr, pc, pc_plus4, valid}.
REQ-033 Sub-module if_id_reg (if_id_t payload, stall/flush inputs, priority per REQ-021) is instantiated once; PC register and counter stay in fetch_unit.

Verification
REQ-034 Reset, then 3 free-running cycles -> pc_f 0x0,0x4,0x8,0xC; instr_d/pc_d track the previous PC; fetch_count=3.
REQ-035 stall_f=stall_d=1 for 2 cycles at pc_f=0x8 -> pc_f, instr_d and fetch_count all hold; execution resumes at 0xC.
REQ-036 pc_src_e=1, pc_target_e=0x100, stall_f=1 in the same cycle -> pc_f=0x100 next edge, valid_d=0 for one cycle, then pc_d=0x100.
REQ-037 pc_target_e=0x102 with pc_src_e=1 -> pc_f=0x100, misalign_err=1 and sticky until reset.
REQ-038 flush_d=1 and stall_d=1 together -> instr_d=0x0000_0013, valid_d=0, fetch_count unchanged.
REQ-039 pc_f=0xFFFF_FFFC, no stall -> pc_f=0x0; reset asserted during a stall -> pc_f=RESET_PC, misalign_err=0, fetch_count=0.
